updown_sweep_ctrl: RTL and testbench
====================================

# updown_sweep_ctrl

Sequencing controller for the lab's WIDTH-bit up/down counter, which has a load input, an enable and an `up` direction input. On a start command it loads the counter with a low bound. It then drives the counter back and forth between the low and high bounds for a programmed number of sweeps, signals completion, and parks the counter at the low bound. It sits beside the counter; the counter's `out` is fed back as `cnt_val`.

## Interface
- WIDTH, 3: counter and bound width, in bits.
- SWW, 4: width of the sweep-count fields.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- abort  in  1  stops any operation; the block returns to IDLE.
- lo  in  WIDTH  low bound (unsigned); latched on an accepted start.
- hi  in  WIDTH  high bound (unsigned); latched on an accepted start.
- n_sweeps  in  SWW  number of sweeps; latched on an accepted start.
- cnt_val  in  WIDTH  current counter value, taken from the counter's `out`.
- cnt_load  out  1  load strobe to the counter.
- cnt_ld_val  out  WIDTH  load value; equals the latched lo.
- cnt_en  out  1  count enable to the counter.
- cnt_up  out  1  direction to the counter: 1 = up, 0 = down.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when a start is rejected.
- sweeps_done  out  SWW  number of sweeps completed in the current or last run.

## Operation
- States: IDLE, LOAD, UP, DOWN, DONE. Registers: state, lo_r, hi_r, n_r, sweeps_done, err.
- Output decode (Moore, from state only):
  - cnt_load = (LOAD).
  - cnt_en = (UP or DOWN).
  - cnt_up = (UP).
  - done = (DONE).
  - busy = (state != IDLE).
  - cnt_ld_val = lo_r.
- Start check in IDLE: a start is accepted only if lo < hi and n_sweeps != 0.
  - Accepted: latch lo, hi and n_sweeps; clear sweeps_done; go to LOAD.
  - Rejected: err = 1 for the next cycle; stay in IDLE; the latched bounds are unchanged.
- LOAD -> UP unconditionally. The counter presents lo in the first UP cycle.
- UP: when cnt_val == hi_r - 1, go to DOWN; otherwise stay in UP.
- DOWN: when cnt_val == lo_r + 1, increment sweeps_done.
  - If the new count == n_r, go to DONE.
  - Otherwise go to UP.
  - If cnt_val != lo_r + 1, stay in DOWN.
- DONE -> IDLE unconditionally. The counter holds lo, because cnt_en = 0.
- Start while busy is ignored.
- Abort in any non-IDLE state: go to IDLE on the next edge. sweeps_done keeps its value and done does not fire.
- Priority: reset > abort > start and normal transitions. If start and abort arrive together in IDLE, abort wins: no load and no err.
- Arithmetic: all compares are unsigned at WIDTH bits. hi_r - 1 and lo_r + 1 cannot wrap because lo < hi is enforced. sweeps_done is SWW bits and never exceeds n_r.
- Minimum span hi = lo + 1: UP lasts one cycle, because cnt_val == lo == hi - 1 is already true.

## Timing
- Reset values (all outputs): state IDLE, cnt_load 0, cnt_en 0, cnt_up 0, busy 0, done 0, err 0, sweeps_done 0. cnt_ld_val is 0 because lo_r resets to 0.
- Accepted start sampled at edge T:
  - LOAD during cycle T+1.
  - First UP cycle at T+2, with cnt_val = lo.
- Each sweep has 2*(hi-lo) enabled cycles.
- The done pulse occurs at T + 2 + 2*(hi-lo)*n. During that cycle cnt_val = lo. busy drops the following cycle.
- err is high during cycle T+1 after a rejected start.
- A new start is accepted in the first IDLE cycle after DONE.
- A reset asserted in any state takes effect at the next edge with the reset values above; the counter stops immediately because cnt_en = 0.

## Test plan
- Single sweep: reset, then lo=2, hi=5, n=1, start at T.
  - cnt_load high at T+1.
  - cnt_val at T+2..T+8: 2,3,4,5,4,3,2.
  - done at T+8 with sweeps_done=1; busy=0 at T+9.
- Multiple sweeps, minimum span: lo=0, hi=1, n=3. cnt_val alternates 0,1 and done is asserted 8 cycles after start, with sweeps_done=3.
- Rejects:
  - lo=4, hi=4, n=1: err pulse at T+1, busy stays 0, no cnt_load.
  - lo=1, hi=6, n=0: same err behaviour.
  - lo=6, hi=1, n=1: same err behaviour.
- Abort: lo=1, hi=7, n=2; assert abort in the 4th DOWN cycle. The next cycle shows IDLE with cnt_en=0, done stays 0, and sweeps_done=0.
- Full range, start ignored while busy: lo=0, hi=7, n=2, with start re-pulsed mid-run. cnt_val reaches 7 without wrapping, the second start has no effect, and done is asserted 30 cycles after start.
- Reset mid-run: assert reset during UP. Next cycle all outputs are at reset values. A new start with lo=3, hi=5, n=1 completes normally, with done asserted 6 cycles after start.

Source files
------------

// File: rtl/updown_sweep_ctrl_if.sv
// Handshake and counter-control bundle shared by the sweep controller and its environment.
// The master side drives commands and the counter feedback; the slave side is the controller.
interface updown_sweep_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int SWW   = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [SWW-1:0]   n_sweeps;
    logic [WIDTH-1:0] cnt_val;

    logic             cnt_load;
    logic [WIDTH-1:0] cnt_ld_val;
    logic             cnt_en;
    logic             cnt_up;
    logic             busy;
    logic             done;
    logic             err;
    logic [SWW-1:0]   sweeps_done;

    modport master (
        output start, abort, lo, hi, n_sweeps, cnt_val,
        input  cnt_load, cnt_ld_val, cnt_en, cnt_up, busy, done, err, sweeps_done
    );

    modport slave (
        input  start, abort, lo, hi, n_sweeps, cnt_val,
        output cnt_load, cnt_ld_val, cnt_en, cnt_up, busy, done, err, sweeps_done
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sweeps an external up/down counter between latched low and high bounds for a programmed
// number of round trips, then parks it at the low bound and pulses done.
module updown_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int SWW   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_sweep_ctrl_if.slave    bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [SWW-1:0]   n_r;
    logic [SWW-1:0]   sweeps_done_r;
    logic             err_r;

    logic             start_ok;
    logic             accept;
    logic             reject;
    logic             sweep_end;
    logic [SWW-1:0]   sweeps_inc;

    // A run needs a non-empty span and at least one sweep; this also keeps hi_r-1 and lo_r+1 from wrapping.
    assign start_ok   = (bus.lo < bus.hi) && (bus.n_sweeps != '0);
    assign sweeps_inc = sweeps_done_r + SWW'(1);

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        sweep_end = 1'b0;

        if (state != S_IDLE && bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // Abort coinciding with start in IDLE suppresses both the load and the error pulse.
                    if (bus.start && !bus.abort) begin
                        if (start_ok) begin
                            accept    = 1'b1;
                            state_nxt = S_LOAD;
                        end else begin
                            reject    = 1'b1;
                        end
                    end
                end
                S_LOAD: state_nxt = S_UP;
                S_UP: begin
                    // The turn is decided one step early: the counter reaches hi on the same edge.
                    if (bus.cnt_val == hi_r - WIDTH'(1))
                        state_nxt = S_DOWN;
                end
                S_DOWN: begin
                    if (bus.cnt_val == lo_r + WIDTH'(1)) begin
                        sweep_end = 1'b1;
                        state_nxt = (sweeps_inc == n_r) ? S_DONE : S_UP;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            lo_r          <= '0;
            hi_r          <= '0;
            n_r           <= '0;
            sweeps_done_r <= '0;
            err_r         <= 1'b0;
        end else begin
            state <= state_nxt;
            err_r <= reject;
            if (accept) begin
                lo_r          <= bus.lo;
                hi_r          <= bus.hi;
                n_r           <= bus.n_sweeps;
                sweeps_done_r <= '0;
            end else if (sweep_end) begin
                sweeps_done_r <= sweeps_inc;
            end
        end
    end

    // Moore decode: outputs depend on the registered state only.
    assign bus.cnt_load    = (state == S_LOAD);
    assign bus.cnt_en      = (state == S_UP) || (state == S_DOWN);
    assign bus.cnt_up      = (state == S_UP);
    assign bus.done        = (state == S_DONE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.cnt_ld_val  = lo_r;
    assign bus.err         = err_r;
    assign bus.sweeps_done = sweeps_done_r;

    a_bounds_ordered: assert property (@(posedge clk) disable iff (reset)
        (state != S_IDLE) |-> (lo_r < hi_r));
    a_sweeps_capped: assert property (@(posedge clk) disable iff (reset)
        (state != S_IDLE) |-> (sweeps_done_r <= n_r));
    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        state <= S_DONE);

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with a behavioural model of the lab up/down counter.
module tb_updown_sweep_ctrl;

    localparam int WIDTH = 3;
    localparam int SWW   = 4;

    logic clk = 1'b0;
    logic reset;
    logic [WIDTH-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    updown_sweep_ctrl_if #(.WIDTH(WIDTH), .SWW(SWW)) bus ();

    updown_sweep_ctrl #(.WIDTH(WIDTH), .SWW(SWW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Lab counter: load has priority over enable.
    always @(posedge clk) begin
        if (reset)             cnt <= '0;
        else if (bus.cnt_load) cnt <= bus.cnt_ld_val;
        else if (bus.cnt_en)   cnt <= bus.cnt_up ? cnt + 3'd1 : cnt - 3'd1;
    end
    assign bus.cnt_val = cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start for one edge; returns in the LOAD cycle of an accepted start.
    task automatic start_cmd(input int l, input int h, input int n);
        bus.lo       = WIDTH'(l);
        bus.hi       = WIDTH'(h);
        bus.n_sweeps = SWW'(n);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 1;
        while (!bus.done && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int cycles;
        int down_cnt;
        int max_seen;
        logic err_seen;
        int ss_seq[7];
        ss_seq = '{2, 3, 4, 5, 4, 3, 2};

        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.lo       = '0;
        bus.hi       = '0;
        bus.n_sweeps = '0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_busy",   bus.busy,        0);
        check("rst_load",   bus.cnt_load,    0);
        check("rst_en",     bus.cnt_en,      0);
        check("rst_up",     bus.cnt_up,      0);
        check("rst_done",   bus.done,        0);
        check("rst_err",    bus.err,         0);
        check("rst_sweeps", bus.sweeps_done, 0);
        check("rst_ldval",  bus.cnt_ld_val,  0);

        // Single sweep 2..5.
        start_cmd(2, 5, 1);
        check("ss_load",  bus.cnt_load, 1);
        check("ss_busy",  bus.busy,     1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("ss_cnt", cnt, ss_seq[i]);
            check("ss_done", bus.done, (i == 6) ? 1 : 0);
            if (i == 0) check("ss_up_first", bus.cnt_up, 1);
            if (i == 3) check("ss_down_at_hi", bus.cnt_up, 0);
        end
        check("ss_sweeps", bus.sweeps_done, 1);
        tick();
        check("ss_busy_after", bus.busy, 0);
        check("ss_cnt_parked", cnt, 2);

        // Rejected starts leave state and latched bounds alone.
        for (int v = 0; v < 3; v++) begin
            case (v)
                0:       start_cmd(4, 4, 1);
                1:       start_cmd(1, 6, 0);
                default: start_cmd(6, 1, 1);
            endcase
            check("rej_err",   bus.err,        1);
            check("rej_busy",  bus.busy,       0);
            check("rej_load",  bus.cnt_load,   0);
            check("rej_ldval", bus.cnt_ld_val, 2);
            tick();
            check("rej_err_pulse", bus.err,  0);
            check("rej_busy2",     bus.busy, 0);
        end

        // Start and abort together in IDLE: abort wins.
        bus.abort = 1'b1;
        start_cmd(1, 2, 1);
        bus.abort = 1'b0;
        check("sa_load", bus.cnt_load, 0);
        check("sa_err",  bus.err,      0);
        check("sa_busy", bus.busy,     0);

        // Minimum span, three sweeps.
        start_cmd(0, 1, 3);
        cycles = 1;
        while (!bus.done && cycles < 100) begin
            tick();
            cycles++;
            if (bus.cnt_en) check("ms_alt", cnt, bus.cnt_up ? 0 : 1);
        end
        check("ms_latency", cycles, 8);
        check("ms_sweeps",  bus.sweeps_done, 3);
        check("ms_cnt",     cnt, 0);
        tick();

        // Abort in the fourth DOWN cycle of a 1..7 run.
        start_cmd(1, 7, 2);
        down_cnt = 0;
        cycles   = 0;
        while (down_cnt < 4 && cycles < 100) begin
            tick();
            cycles++;
            if (bus.cnt_en && !bus.cnt_up) down_cnt++;
        end
        check("ab_reached", down_cnt, 4);
        check("ab_cnt", cnt, 4);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab_busy",   bus.busy,        0);
        check("ab_en",     bus.cnt_en,      0);
        check("ab_done",   bus.done,        0);
        check("ab_sweeps", bus.sweeps_done, 0);
        tick();
        check("ab_done2",  bus.done,        0);

        // Full range with an ignored re-start mid-run.
        start_cmd(0, 7, 2);
        check("fr_load", bus.cnt_load, 1);
        cycles   = 1;
        max_seen = 0;
        err_seen = 1'b0;
        while (!bus.done && cycles < 100) begin
            if (cycles == 10) begin
                bus.lo = 3'd2; bus.hi = 3'd3; bus.n_sweeps = 4'd1; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cycles++;
            if (int'(cnt) > max_seen) max_seen = int'(cnt);
            if (bus.err) err_seen = 1'b1;
        end
        bus.start = 1'b0;
        check("fr_latency", cycles, 30);
        check("fr_max",     max_seen, 7);
        check("fr_sweeps",  bus.sweeps_done, 2);
        check("fr_err",     err_seen, 0);
        check("fr_ldval",   bus.cnt_ld_val, 0);
        check("fr_cnt",     cnt, 0);
        tick();

        // Reset during UP, then a clean run.
        start_cmd(1, 6, 1);
        tick();
        tick();
        check("rm_in_up", bus.cnt_up, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_busy",   bus.busy,        0);
        check("rm_load",   bus.cnt_load,    0);
        check("rm_en",     bus.cnt_en,      0);
        check("rm_up",     bus.cnt_up,      0);
        check("rm_done",   bus.done,        0);
        check("rm_err",    bus.err,         0);
        check("rm_sweeps", bus.sweeps_done, 0);
        check("rm_ldval",  bus.cnt_ld_val,  0);
        start_cmd(3, 5, 1);
        wait_done(100, cycles);
        check("rm_latency", cycles, 6);
        check("rm_sweeps2", bus.sweeps_done, 1);
        check("rm_cnt",     cnt, 3);
        tick();
        check("rm_busy_end", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
